// File: rtl/tis_pkg.sv
// Shared TIS grid definitions: neighbour port indices, default word width,
// operand encodings common with the compute core, and small index helpers.
package tis_pkg;

   localparam int WIDTH_DEFAULT = 11;

   localparam int PORT_LEFT  = 0;
   localparam int PORT_RIGHT = 1;
   localparam int PORT_UP    = 2;
   localparam int PORT_DOWN  = 3;

   typedef enum logic [1:0] {
      OPD_NIL  = 2'd0,
      OPD_ACC  = 2'd1,
      OPD_ANY  = 2'd2,
      OPD_LAST = 2'd3
   } operand_e;

   // Next port index with wrap-around from n-1 back to 0.
   function automatic int wrap_inc(input int i, input int n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/tis_stack_node_if.sv
// Neighbour-facing handshake bundle of the stack node: push side (rready/in_data/read)
// and pop side (write/wready/out).
interface tis_stack_node_if
   import tis_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEFAULT,
   parameter int NPORTS = 4
);
   logic [NPORTS-1:0]            rready;
   logic [NPORTS-1:0][WIDTH-1:0] in_data;
   logic [NPORTS-1:0]            read;
   logic [NPORTS-1:0]            wready;
   logic [NPORTS-1:0]            write;
   logic [WIDTH-1:0]             out;

   modport master (
      output rready, in_data, wready,
      input  read, write, out
   );

   modport slave (
      input  rready, in_data, wready,
      output read, write, out
   );
endinterface

// File: rtl/tis_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester at or after ptr
// (wrapping) is granted, reported one-hot and as an index.
module tis_rr_arbiter
   import tis_pkg::*;
#(
   parameter  int NPORTS = 4,
   localparam int IW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
   input  logic [NPORTS-1:0] req,
   input  logic [IW-1:0]     ptr,
   output logic [NPORTS-1:0] gnt,
   output logic [IW-1:0]     gnt_idx,
   output logic              gnt_valid
);

   always_comb begin
      int scan;
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      scan      = int'(ptr);
      for (int k = 0; k < NPORTS; k++) begin
         if (!gnt_valid && req[scan]) begin
            gnt_valid = 1'b1;
            gnt[scan] = 1'b1;
            gnt_idx   = IW'(scan);
         end
         scan = wrap_inc(scan, NPORTS);
      end
   end

endmodule

// File: rtl/tis_stack_node.sv
// LIFO storage node for the TIS grid: any neighbour may push (round-robin
// arbitrated, one per cycle) and any neighbour may pop the top word.
module tis_stack_node
   import tis_pkg::*;
#(
   parameter  int WIDTH  = WIDTH_DEFAULT,
   parameter  int DEPTH  = 15,
   parameter  int NPORTS = 4,
   localparam int CW     = $clog2(DEPTH + 1),
   localparam int IW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   tis_stack_node_if.slave   bus,
   output logic [CW-1:0]     count,
   output logic              full,
   output logic              empty
);

   logic [WIDTH-1:0]  mem [DEPTH];

   logic [CW-1:0]     count_reg, count_next, count_popped;
   logic [IW-1:0]     rr_ptr_reg, rr_ptr_next;
   logic [NPORTS-1:0] read_reg, read_next;
   logic [NPORTS-1:0] write_reg, write_next;

   logic [NPORTS-1:0] elig;
   logic [NPORTS-1:0] gnt;
   logic [IW-1:0]     gnt_idx;
   logic              gnt_valid;
   logic              pop;

   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;

   // A port still seeing its read pulse is retiring the captured word; skip it.
   for (genvar gi = 0; gi < NPORTS; gi++) begin : g_elig
      assign elig[gi] = bus.rready[gi] && !read_reg[gi] && !full;
   end

   tis_rr_arbiter #(.NPORTS(NPORTS)) u_arb (
      .req       (elig),
      .ptr       (rr_ptr_reg),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   // Pop is applied before push, so a simultaneous push lands in the vacated slot.
   always_comb begin
      pop          = (write_reg != '0) && ((bus.wready & write_reg) != '0);
      count_popped = count_reg - CW'(pop);
      count_next   = count_popped + CW'(gnt_valid);
      read_next    = gnt_valid ? gnt : '0;
      write_next   = ((count_next != '0) && !pop) ? '1 : '0;
      rr_ptr_next  = gnt_valid ? IW'(wrap_inc(int'(gnt_idx), NPORTS)) : rr_ptr_reg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg  <= '0;
         rr_ptr_reg <= '0;
         read_reg   <= '0;
         write_reg  <= '0;
      end else begin
         count_reg  <= count_next;
         rr_ptr_reg <= rr_ptr_next;
         read_reg   <= read_next;
         write_reg  <= write_next;
      end
   end

   // Storage has no reset: contents are meaningless once count drops.
   always_ff @(posedge clk) begin
      if (gnt_valid) begin
         mem[count_popped] <= bus.in_data[gnt_idx];
      end
   end

   assign bus.read  = read_reg;
   assign bus.write = write_reg;
   assign bus.out   = empty ? '0 : mem[count_reg - 1'b1];

endmodule

// File: doc/tis_stack_node.md
# tis_stack_node

Parametrised LIFO storage node for the TIS grid. It sits in a grid slot beside the compute cores and uses the same per-direction neighbour handshake. Any neighbour may push a word into the node, and any neighbour may pop the top word from it. Depth, word width and port count are generics. Push arbitration across ports is round-robin, so a single neighbour cannot starve the others.

## Interface
Parameters:
- WIDTH, 11: signed word width; equals the core data width.
- DEPTH, 15: number of stack entries (≥1).
- NPORTS, 4: neighbour port count. Bit i maps to port i: 0=LEFT, 1=RIGHT, 2=UP, 3=DOWN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rready  in  NPORTS  neighbour i presents a word for this node
- in_data  in  NPORTS×WIDTH  word from neighbour i
- read  out  NPORTS  one-cycle consume pulse to neighbour i
- wready  in  NPORTS  neighbour i consumed the offered word this cycle
- write  out  NPORTS  offer mask; all ones while a word is offered
- out  out  WIDTH  top-of-stack word; 0 when empty
- count  out  $clog2(DEPTH+1)  current occupancy
- full  out  1  count==DEPTH
- empty  out  1  count==0

## Operation
- Storage: DEPTH×WIDTH register array plus a `count` pointer. The top entry is mem[count-1].
- Push eligibility for port i: rready[i] && !read[i] && !full.
  - The `!read[i]` term blocks double capture while the neighbour is still retiring its word.
- Push arbitration:
  - Among eligible ports, grant exactly one per cycle, using rotating priority that starts at `rr_ptr`.
  - On a grant to port g, rr_ptr ← (g+1) mod NPORTS.
- Push action on the clock edge: write in_data[g] to mem[count], and pulse read[g]=1 for the next cycle only.
- Pop: at an edge where write!=0 and (wready & write)!=0, the top entry is removed.
  - If several wready bits are high together, it counts as a single pop; neighbours must not do this, and the bench flags it as an error.
- Simultaneous push and pop in one cycle: the pop is applied first, then the push.
  - count is unchanged.
  - The new top is the pushed word, written into the slot just vacated.
- Full is evaluated on pre-edge state. A pop in the same cycle does not make a full stack eligible for push; the push waits one cycle.
- Offer: write ← all ones when the post-update stack is non-empty and no pop occurred this edge; otherwise write ← 0.
  - This gives a mandatory one-cycle gap after every pop, so neighbours observe the new `out`.
- Arithmetic: stored words are opaque. There is no saturation or sign handling; out passes bits unchanged.

## Timing
- Reset (async) values:
  - write=0, read=0, out=0
  - count=0, empty=1, full=0
  - rr_ptr=0
  - mem contents don't-care
- Push latency: when rready is captured at edge N, count updates at N, read is high in cycle N..N+1, and write is high from N+1 if the stack was empty.
- Pop latency: when wready is seen at edge M, count decrements at M and write=0 during cycle M..M+1. write is reasserted at edge M+1 if the stack is non-empty.
- Throughput: 1 push per cycle across all ports; 1 pop per 2 cycles.
- Reset mid-operation discards all entries and pending read/write pulses immediately. No partial pop or push survives.
- The wrap-around of rr_ptr from NPORTS-1 to 0 is required.
- count saturates structurally: push is never granted at DEPTH, and pop is never accepted at 0 because write=0.

## Structure
- Shared package `tis_pkg`:
  - port index constants PORT_LEFT..PORT_DOWN
  - default WIDTH
  - NIL/ACC/ANY/LAST operand encodings, shared with the core
- Sub-module `tis_rr_arbiter`: NPORTS-wide request, pointer in, one-hot grant plus grant index out; purely combinational.
- The stack node instantiates it once.

## Test plan
- Reset, then push 5 from LEFT → read[0] pulses one cycle; next cycle write=4'b1111, out=5, count=1.
- Push 1,2,3 from UP, then pop via wready[1] each time write is high → pops return 3,2,1, each followed by a write=0 gap cycle; empty=1 at the end.
- rready on all four ports held continuously, each neighbour presenting its own constant value (LEFT=10, RIGHT=11, UP=12, DOWN=13) and dropping rready after its read pulse → grants in order 0,1,2,3; stored order 10,11,12,13.
- Fill to DEPTH=15, with rready[3] held and in_data[3]=77 → no read pulse and full=1. After one pop, 77 is pushed on the following cycle.
- With count=2 and top=9, assert wready[0] together with rready[2] and in_data[2]=-4 → count stays 2, out=-4, write=0 for one cycle, then reasserted.
- Assert rst for one cycle with count=6 while read[1]=1 → all outputs return to reset values in the same cycle.
